// File: rtl/sc_param_counter.sv
// sc_param_counter: parametrised up/down game-timing counter with prescaler,
// wrap/saturate limits, terminal-count pulse and sticky overflow flag.
module sc_param_counter #(
  parameter int COUNT_WIDTH = 6,
  parameter int COUNT_MAX   = 2**COUNT_WIDTH-1,
  parameter int PRESCALE    = 1,
  parameter bit SATURATE    = 1'b0
) (
  input  logic                   SC_upCOUNTER_2_CLOCK_50,
  input  logic                   SC_upCOUNTER_2_RESET_InHigh,
  input  logic                   SC_COUNTER_enable_InHigh,
  input  logic                   SC_COUNTER_dir_InHigh,
  input  logic                   SC_COUNTER_clear_InHigh,
  input  logic                   SC_COUNTER_load_InHigh,
  input  logic [COUNT_WIDTH-1:0] SC_COUNTER_load_InBUS,
  output logic [COUNT_WIDTH-1:0] SC_COUNTER_data_OutBUS,
  output logic                   SC_COUNTER_tick_Out,
  output logic                   SC_COUNTER_terminal_Out,
  output logic                   SC_COUNTER_overflow_Out,
  output logic                   SC_COUNTER_atlimit_Out
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [COUNT_WIDTH-1:0] MAXV = COUNT_WIDTH'(COUNT_MAX);
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE-1);

  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]          pre_q, pre_d;
  logic                   tick_q, tick_d, term_q, term_d, ovf_q, ovf_d;
  logic                   at_lim, step, bnd;

  always_comb begin
    at_lim  = SC_COUNTER_dir_InHigh ? count_q == MAXV : count_q == '0;
    step    = SC_COUNTER_enable_InHigh & ~SC_COUNTER_clear_InHigh & ~SC_COUNTER_load_InHigh & (pre_q == PLAST);
    bnd     = step & at_lim;
    pre_d   = (SC_COUNTER_clear_InHigh | SC_COUNTER_load_InHigh) ? '0 :
              ~SC_COUNTER_enable_InHigh ? pre_q :
              (pre_q == PLAST) ? '0 : pre_q + 1'b1;
    count_d = SC_COUNTER_clear_InHigh ? '0 :
              SC_COUNTER_load_InHigh ? (SC_COUNTER_load_InBUS > MAXV ? MAXV : SC_COUNTER_load_InBUS) :
              ~step ? count_q :
              bnd ? (SATURATE ? count_q : SC_COUNTER_dir_InHigh ? '0 : MAXV) :
              SC_COUNTER_dir_InHigh ? count_q + 1'b1 : count_q - 1'b1;
    tick_d  = step;
    term_d  = bnd;
    ovf_d   = ~SC_COUNTER_clear_InHigh & (ovf_q | bnd);
  end

  always_ff @(posedge SC_upCOUNTER_2_CLOCK_50 or posedge SC_upCOUNTER_2_RESET_InHigh) begin
    if (SC_upCOUNTER_2_RESET_InHigh) begin
      count_q <= '0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      term_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      term_q  <= term_d;
      ovf_q   <= ovf_d;
    end
  end

  // atlimit is combinational but still forced low while reset is held
  assign SC_COUNTER_atlimit_Out  = at_lim & ~SC_upCOUNTER_2_RESET_InHigh;
  assign SC_COUNTER_data_OutBUS  = count_q;
  assign SC_COUNTER_tick_Out     = tick_q;
  assign SC_COUNTER_terminal_Out = term_q;
  assign SC_COUNTER_overflow_Out = ovf_q;
endmodule

// File: tb/tb_sc_param_counter.sv
// tb_sc_param_counter: four counter channels driven in parallel, checked every
// cycle against an integer model plus directed literal expectations.
module tb_sc_param_counter;
  logic clk = 1'b0, rst = 1'b0;
  logic en = 1'b0, dir = 1'b0, clr = 1'b0, ld = 1'b0;
  logic [3:0] ldv = '0;
  logic [2:0] da, db, dc;
  logic [3:0] dd;
  logic [3:0] dout [4];
  logic tk [4], tm [4], ov [4], al [4];
  int checks = 0, errors = 0;
  int mc [4], mp [4], mo [4], mt [4], mk [4];

  always #5 clk = ~clk;

  sc_param_counter #(.COUNT_WIDTH(3), .COUNT_MAX(5), .PRESCALE(1), .SATURATE(1'b0)) u_a (
    .SC_upCOUNTER_2_CLOCK_50(clk), .SC_upCOUNTER_2_RESET_InHigh(rst),
    .SC_COUNTER_enable_InHigh(en), .SC_COUNTER_dir_InHigh(dir),
    .SC_COUNTER_clear_InHigh(clr), .SC_COUNTER_load_InHigh(ld),
    .SC_COUNTER_load_InBUS(ldv[2:0]), .SC_COUNTER_data_OutBUS(da),
    .SC_COUNTER_tick_Out(tk[0]), .SC_COUNTER_terminal_Out(tm[0]),
    .SC_COUNTER_overflow_Out(ov[0]), .SC_COUNTER_atlimit_Out(al[0]));
  sc_param_counter #(.COUNT_WIDTH(3), .COUNT_MAX(5), .PRESCALE(1), .SATURATE(1'b1)) u_b (
    .SC_upCOUNTER_2_CLOCK_50(clk), .SC_upCOUNTER_2_RESET_InHigh(rst),
    .SC_COUNTER_enable_InHigh(en), .SC_COUNTER_dir_InHigh(dir),
    .SC_COUNTER_clear_InHigh(clr), .SC_COUNTER_load_InHigh(ld),
    .SC_COUNTER_load_InBUS(ldv[2:0]), .SC_COUNTER_data_OutBUS(db),
    .SC_COUNTER_tick_Out(tk[1]), .SC_COUNTER_terminal_Out(tm[1]),
    .SC_COUNTER_overflow_Out(ov[1]), .SC_COUNTER_atlimit_Out(al[1]));
  sc_param_counter #(.COUNT_WIDTH(3), .COUNT_MAX(5), .PRESCALE(4), .SATURATE(1'b0)) u_c (
    .SC_upCOUNTER_2_CLOCK_50(clk), .SC_upCOUNTER_2_RESET_InHigh(rst),
    .SC_COUNTER_enable_InHigh(en), .SC_COUNTER_dir_InHigh(dir),
    .SC_COUNTER_clear_InHigh(clr), .SC_COUNTER_load_InHigh(ld),
    .SC_COUNTER_load_InBUS(ldv[2:0]), .SC_COUNTER_data_OutBUS(dc),
    .SC_COUNTER_tick_Out(tk[2]), .SC_COUNTER_terminal_Out(tm[2]),
    .SC_COUNTER_overflow_Out(ov[2]), .SC_COUNTER_atlimit_Out(al[2]));
  sc_param_counter #(.COUNT_WIDTH(4), .COUNT_MAX(9), .PRESCALE(3), .SATURATE(1'b1)) u_d (
    .SC_upCOUNTER_2_CLOCK_50(clk), .SC_upCOUNTER_2_RESET_InHigh(rst),
    .SC_COUNTER_enable_InHigh(en), .SC_COUNTER_dir_InHigh(dir),
    .SC_COUNTER_clear_InHigh(clr), .SC_COUNTER_load_InHigh(ld),
    .SC_COUNTER_load_InBUS(ldv), .SC_COUNTER_data_OutBUS(dd),
    .SC_COUNTER_tick_Out(tk[3]), .SC_COUNTER_terminal_Out(tm[3]),
    .SC_COUNTER_overflow_Out(ov[3]), .SC_COUNTER_atlimit_Out(al[3]));

  always_comb dout = '{{1'b0, da}, {1'b0, db}, {1'b0, dc}, dd};

  function automatic int mx(int i);  return i == 3 ? 9 : 5; endfunction
  function automatic int pv(int i);  return i == 2 ? 4 : (i == 3 ? 3 : 1); endfunction
  function automatic bit sv(int i);  return i == 1 || i == 3; endfunction
  function automatic int msk(int i); return i == 3 ? 15 : 7; endfunction

  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", n, a, e, $time);
    end
  endtask

  // reference: the prescaler counts enabled cycles, a step fires on the PRESCALE-th
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        mc[i] = 0; mp[i] = 0; mo[i] = 0; mt[i] = 0; mk[i] = 0;
      end else begin
        mt[i] = 0; mk[i] = 0;
        if (clr) begin
          mc[i] = 0; mp[i] = 0; mo[i] = 0;
        end else if (ld) begin
          mc[i] = (int'(ldv) & msk(i)) > mx(i) ? mx(i) : (int'(ldv) & msk(i));
          mp[i] = 0;
        end else if (en) begin
          mp[i]++;
          if (mp[i] == pv(i)) begin
            mp[i] = 0; mk[i] = 1;
            if (dir ? mc[i] == mx(i) : mc[i] == 0) begin
              mt[i] = 1; mo[i] = 1;
              if (!sv(i)) mc[i] = dir ? 0 : mx(i);
            end else mc[i] = dir ? mc[i] + 1 : mc[i] - 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("data[%0d]", i), int'(dout[i]), mc[i]);
      chk($sformatf("tick[%0d]", i), int'(tk[i]), mk[i]);
      chk($sformatf("term[%0d]", i), int'(tm[i]), mt[i]);
      chk($sformatf("ovf[%0d]", i), int'(ov[i]), mo[i]);
      chk($sformatf("atlimit[%0d]", i), int'(al[i]), rst ? 0 : int'(dir ? mc[i] == mx(i) : mc[i] == 0));
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int ua [6] = '{1, 2, 3, 4, 5, 0};
    #1 rst = 1'b1;
    cyc(2);
    chk("rst data", int'(da), 0);
    chk("rst ovf", int'(ov[0]), 0);
    rst = 1'b0; en = 1'b1; dir = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("upwrap data", int'(da), ua[k]);
      if (k == 4) chk("upwrap atlimit", int'(al[0]), 1);
    end
    chk("upwrap term", int'(tm[0]), 1);
    chk("upwrap ovf", int'(ov[0]), 1);
    en = 1'b0;
    cyc();
    chk("upwrap term pulse", int'(tm[0]), 0);
    ld = 1'b1; ldv = 4'd3;
    cyc();
    ld = 1'b0;
    #2 rst = 1'b1;
    #1 chk("async data", int'(da), 0);
    chk("async ovf", int'(ov[0]), 0);
    cyc();
    chk("async hold", int'(da), 0);
    rst = 1'b0; ld = 1'b1; ldv = 4'd2;
    cyc();
    ld = 1'b0; en = 1'b1; dir = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("dsat data", int'(db), k == 0 ? 1 : 0);
      chk("dsat term", int'(tm[1]), k >= 2 ? 1 : 0);
      chk("dsat tick", int'(tk[1]), 1);
    end
    clr = 1'b1; en = 1'b0;
    cyc();
    clr = 1'b0; en = 1'b1; dir = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk("pre tick", int'(tk[2]), k % 4 == 0 ? 1 : 0);
    end
    chk("pre data", int'(dc), 3);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    cyc(6);
    chk("pre pause start", int'(dc), 1);
    en = 1'b0;
    cyc(5);
    chk("pre paused", int'(dc), 1);
    en = 1'b1;
    cyc();
    chk("pre resume1", int'(dc), 1);
    cyc();
    chk("pre resume2", int'(dc), 2);
    clr = 1'b1; ld = 1'b1; ldv = 4'd4;
    cyc();
    chk("prio data", int'(da), 0);
    chk("prio ovf", int'(ov[0]), 0);
    clr = 1'b0; ldv = 4'd7;
    cyc();
    chk("clamp data", int'(da), 5);
    ld = 1'b0; clr = 1'b1;
    cyc();
    clr = 1'b0;
    cyc(2);
    ld = 1'b1; ldv = 4'd1;
    cyc();
    chk("preload data", int'(dc), 1);
    ld = 1'b0;
    cyc(3);
    chk("preload wait", int'(dc), 1);
    cyc();
    chk("preload step", int'(dc), 2);
    en = 1'b0; ld = 1'b1; ldv = 4'd5;
    cyc();
    ld = 1'b0; dir = 1'b1;
    #1 chk("flip atlimit up", int'(al[0]), 1);
    dir = 1'b0;
    #1 chk("flip atlimit down", int'(al[0]), 0);
    en = 1'b1;
    cyc();
    chk("flip data", int'(da), 4);
    chk("flip term", int'(tm[0]), 0);
    for (int k = 0; k < 800; k++) begin
      en  = ($urandom % 4) != 0;
      dir = $urandom % 2;
      clr = ($urandom % 40) == 0;
      ld  = ($urandom % 25) == 0;
      ldv = 4'($urandom);
      cyc();
      if ($urandom % 150 == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
